pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Instruction-fetch and next-PC sequencer. It consumes the ALU's branch and jump decisions, which are the other end of the ALU Branch_out/Jump_out interface.
- Fetches one instruction at a time over a request/acknowledge instruction-memory port and presents it to decode with a valid/ready handshake.
- Waits for the executed instruction's resolution, then computes the next PC. Non-speculative: one instruction in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0
OFFSET_W, 16, width of branch offset field (sign-extended)

Ports:
Clk_in  input  1  clock, rising edge
Rst_n_in  input  1  asynchronous active-low reset
Imem_req_out  output  1  instruction-memory read request
Imem_addr_out  output  32  read address (current PC)
Imem_ack_in  input  1  memory acknowledge; Imem_data_in valid this cycle
Imem_data_in  input  32  instruction word
Instr_out  output  32  instruction presented to decode
Instr_valid_out  output  1  Instr_out valid
Instr_ready_in  input  1  decode accepts Instr_out
Pc_out  output  32  PC of Instr_out / current fetch PC
Resolve_valid_in  input  1  execution of issued instruction complete
Branch_in  input  1  branch taken (ALU Branch_out)
Jump_in  input  1  jump taken (ALU Jump_out)
Branch_offset_in  input  OFFSET_W  word offset for branch
Jump_target_in  input  32  absolute jump target (ALU O_out)
Halt_in  input  1  stop fetching after current instruction
Halted_out  output  1  sequencer idle in HALT
Fault_out  output  1  sticky misaligned-target fault
Retire_count_out  output  32  resolved-instruction counter

Behaviour:
- Reset (Rst_n_in=0, async): state=BOOT. PC=RESET_PC. Imem_req_out=0, Imem_addr_out=RESET_PC, Instr_out=0, Instr_valid_out=0, Pc_out=RESET_PC, Halted_out=0, Fault_out=0, Retire_count_out=0. A reset mid-transaction abandons any outstanding request or instruction.
- All outputs are registered or decoded from the state register only. No combinational input-to-output path.
- BOOT -> FETCH on the first rising edge after reset release.
- FETCH:
  - Imem_req_out=1, Imem_addr_out=PC, both held stable until ack.
  - Ack is sampled on every FETCH cycle, including the first.
  - On Imem_ack_in=1: capture Imem_data_in into Instr_out and go to ISSUE. Imem_req_out drops in the following cycle.
  - Imem_ack_in outside FETCH is ignored.
- ISSUE:
  - Instr_valid_out=1. Instr_out and Pc_out are held stable until Instr_ready_in=1.
  - On accept, go to RESOLVE; Instr_valid_out=0 next cycle.
- RESOLVE: wait for Resolve_valid_in=1. It is ignored in every other state. When it arrives:
  - Jump_in=1: next=Jump_target_in. Jump has priority over Branch_in.
  - else Branch_in=1: next=PC+4+(sext(Branch_offset_in)<<2).
  - else: next=PC+4.
  - Arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - Retire_count_out increments and wraps at 2^32.
  - next[1:0]!=0: go to FAULT, Fault_out=1, PC unchanged.
  - else PC=next; go to HALT if Halt_in=1, otherwise FETCH.
- HALT: Halted_out=1, no requests. Halt_in=0 -> FETCH at the held PC; Halted_out=0 on that transition.
- FAULT: terminal until reset. No requests, Instr_valid_out=0, Fault_out held at 1.
- Halt_in is sampled only at resolution; it never cancels an outstanding request or issue.
- Minimum throughput (ack and ready both in the first cycle, resolve in the first RESOLVE cycle): 3 cycles per instruction.

Test Plan:
- Sequential fetch, RESET_PC=0, ack and ready immediate, resolve with Branch_in=Jump_in=0 -> Imem_addr_out sequence 0x0,0x4,0x8, Pc_out matches, Retire_count_out=3, 3 cycles per instruction.
- Backward branch at PC=0x20, Branch_offset_in=16'hFFFC -> next fetch address 0x14. Memory ack delayed 3 cycles -> Imem_req_out/Imem_addr_out stable throughout, Instr_out=Imem_data_in captured on the ack cycle.
- Jump_in=1 and Branch_in=1 together, Jump_target_in=0x400, offset=8 -> next fetch at 0x400. PC=0xFFFF_FFFC with no branch -> next fetch at 0x0 (wrap).
- Decode holds Instr_ready_in=0 for 4 cycles -> Instr_valid_out=1 with Instr_out/Pc_out unchanged. Resolve_valid_in pulsed during ISSUE -> ignored, Retire_count_out unchanged.
- Halt_in=1 at resolution -> Halted_out=1, no Imem_req_out. Release Halt_in -> fetch resumes at PC+4.
- Jump_target_in=0x102 -> Fault_out=1, no further requests. Assert Rst_n_in=0 mid-FETCH -> outputs at reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: non-speculative instruction-fetch and next-PC sequencer
// (one instruction in flight: FETCH -> ISSUE -> RESOLVE).
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFFSET_W = 16
) (
  input  logic                Clk_in,
  input  logic                Rst_n_in,
  output logic                Imem_req_out,
  output logic [31:0]         Imem_addr_out,
  input  logic                Imem_ack_in,
  input  logic [31:0]         Imem_data_in,
  output logic [31:0]         Instr_out,
  output logic                Instr_valid_out,
  input  logic                Instr_ready_in,
  output logic [31:0]         Pc_out,
  input  logic                Resolve_valid_in,
  input  logic                Branch_in,
  input  logic                Jump_in,
  input  logic [OFFSET_W-1:0] Branch_offset_in,
  input  logic [31:0]         Jump_target_in,
  input  logic                Halt_in,
  output logic                Halted_out,
  output logic                Fault_out,
  output logic [31:0]         Retire_count_out
);

  localparam logic [2:0] S_BOOT    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]  state_q,  state_d;
  logic [31:0] pc_q,     pc_d;
  logic [31:0] instr_q,  instr_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] offset_sext;
  logic [31:0] next_pc;

  assign offset_sext = 32'($signed(Branch_offset_in));

  // Jump wins over branch; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (Jump_in) begin
      next_pc = Jump_target_in;
    end else if (Branch_in) begin
      next_pc = pc_q + 32'd4 + (offset_sext << 2);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (Imem_ack_in) begin
          instr_d = Imem_data_in;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (Instr_ready_in) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (Resolve_valid_in) begin
          retire_d = retire_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = Halt_in ? S_HALT : S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (!Halt_in) state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  // Handshake and status outputs decode the state register only.
  assign Imem_req_out     = (state_q == S_FETCH);
  assign Imem_addr_out    = pc_q;
  assign Instr_out        = instr_q;
  assign Instr_valid_out  = (state_q == S_ISSUE);
  assign Pc_out           = pc_q;
  assign Halted_out       = (state_q == S_HALT);
  assign Fault_out        = (state_q == S_FAULT);
  assign Retire_count_out = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a scoreboard of expected
// (PC, instruction) pairs checked by a monitor on each decode accept.
`default_nettype none

module tb_pc_sequencer;

  logic        Clk_in = 1'b0;
  logic        Rst_n_in = 1'b0;
  logic        Imem_req_out;
  logic [31:0] Imem_addr_out;
  logic        Imem_ack_in = 1'b0;
  logic [31:0] Imem_data_in = 32'd0;
  logic [31:0] Instr_out;
  logic        Instr_valid_out;
  logic        Instr_ready_in = 1'b0;
  logic [31:0] Pc_out;
  logic        Resolve_valid_in = 1'b0;
  logic        Branch_in = 1'b0;
  logic        Jump_in = 1'b0;
  logic [15:0] Branch_offset_in = 16'd0;
  logic [31:0] Jump_target_in = 32'd0;
  logic        Halt_in = 1'b0;
  logic        Halted_out;
  logic        Fault_out;
  logic [31:0] Retire_count_out;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .OFFSET_W(16)) dut (
    .Clk_in(Clk_in), .Rst_n_in(Rst_n_in),
    .Imem_req_out(Imem_req_out), .Imem_addr_out(Imem_addr_out),
    .Imem_ack_in(Imem_ack_in), .Imem_data_in(Imem_data_in),
    .Instr_out(Instr_out), .Instr_valid_out(Instr_valid_out),
    .Instr_ready_in(Instr_ready_in), .Pc_out(Pc_out),
    .Resolve_valid_in(Resolve_valid_in), .Branch_in(Branch_in),
    .Jump_in(Jump_in), .Branch_offset_in(Branch_offset_in),
    .Jump_target_in(Jump_target_in), .Halt_in(Halt_in),
    .Halted_out(Halted_out), .Fault_out(Fault_out),
    .Retire_count_out(Retire_count_out)
  );

  always #5 Clk_in = ~Clk_in;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  logic [31:0] exp_retire = 32'd0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  always @(posedge Clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every decode accept must match the next expected pair.
  always @(negedge Clk_in) begin
    if (Rst_n_in && Instr_valid_out && Instr_ready_in) begin
      if (exp_pc_q.size() == 0) begin
        assertions++;
        failures++;
        $display("FAIL sb_unexpected: actual pc=%h expected none", Pc_out);
      end else begin
        check("sb_pc", Pc_out, exp_pc_q.pop_front());
        check("sb_instr", Instr_out, exp_ins_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic do_instr(input logic [31:0] pc, input int ack_dly, input int rdy_dly,
                          input logic br, input logic jp, input logic [15:0] off,
                          input logic [31:0] tgt, input logic hlt, input logic pulse,
                          output int start_cyc);
    int n;
    logic [31:0] data;
    data = pc ^ 32'hC0DE_0000;
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(data);
    n = 0;
    while (!Imem_req_out && n < 20) begin tick(); n++; end
    check("req_seen", {31'd0, Imem_req_out}, 32'd1);
    start_cyc = cyc;
    check("fetch_addr", Imem_addr_out, pc);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("req_hold", {31'd0, Imem_req_out}, 32'd1);
      check("addr_hold", Imem_addr_out, pc);
    end
    Imem_ack_in = 1'b1;
    Imem_data_in = data;
    tick();
    Imem_ack_in = 1'b0;
    Imem_data_in = 32'hDEAD_BEEF;
    n = 0;
    while (!Instr_valid_out && n < 20) begin tick(); n++; end
    check("valid_seen", {31'd0, Instr_valid_out}, 32'd1);
    check("req_dropped", {31'd0, Imem_req_out}, 32'd0);
    check("instr_cap", Instr_out, data);
    for (int i = 0; i < rdy_dly; i++) begin
      Resolve_valid_in = pulse && (i == 0);
      tick();
      Resolve_valid_in = 1'b0;
      check("valid_hold", {31'd0, Instr_valid_out}, 32'd1);
      check("instr_hold", Instr_out, data);
      check("pc_hold", Pc_out, pc);
    end
    Instr_ready_in = 1'b1;
    tick();
    Instr_ready_in = 1'b0;
    check("valid_drop", {31'd0, Instr_valid_out}, 32'd0);
    check("retire_pre", Retire_count_out, exp_retire);
    Resolve_valid_in = 1'b1;
    Branch_in = br;
    Jump_in = jp;
    Branch_offset_in = off;
    Jump_target_in = tgt;
    Halt_in = hlt;
    tick();
    Resolve_valid_in = 1'b0;
    Branch_in = 1'b0;
    Jump_in = 1'b0;
    exp_retire = exp_retire + 32'd1;
    check("retire", Retire_count_out, exp_retire);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'd0, Imem_req_out}, 32'd0);
    check("rst_addr", Imem_addr_out, 32'h0);
    check("rst_instr", Instr_out, 32'h0);
    check("rst_valid", {31'd0, Instr_valid_out}, 32'd0);
    check("rst_pc", Pc_out, 32'h0);
    check("rst_halted", {31'd0, Halted_out}, 32'd0);
    check("rst_fault", {31'd0, Fault_out}, 32'd0);
    check("rst_retire", Retire_count_out, 32'd0);
  endtask

  initial begin
    int c0, c1, c2;
    #12;
    check_reset_outputs();
    Rst_n_in = 1'b1;
    tick();

    // Sequential fetch at three cycles per instruction.
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c0);
    do_instr(32'h4, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c1);
    do_instr(32'h8, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c2);
    check("tput_1", c1 - c0, 32'd3);
    check("tput_2", c2 - c1, 32'd3);
    check("retire_3", Retire_count_out, 32'd3);

    // Jump to 0x20, backward branch with slow memory, jump beats branch.
    do_instr(32'hC,  0, 0, 1'b0, 1'b1, 16'h0,    32'h20,  1'b0, 1'b0, c0);
    do_instr(32'h20, 3, 0, 1'b1, 1'b0, 16'hFFFC, 32'h0,   1'b0, 1'b0, c0);
    do_instr(32'h14, 0, 0, 1'b1, 1'b1, 16'h0008, 32'h400, 1'b0, 1'b0, c0);

    // Decode stall with a stray resolve pulse, then PC wrap-around.
    do_instr(32'h400, 0, 4, 1'b0, 1'b1, 16'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, c0);
    do_instr(32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c0);

    // Halt at resolution, then release.
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, c0);
    for (int i = 0; i < 3; i++) begin
      check("halted", {31'd0, Halted_out}, 32'd1);
      check("halt_noreq", {31'd0, Imem_req_out}, 32'd0);
      tick();
    end
    Halt_in = 1'b0;
    tick();
    check("unhalted", {31'd0, Halted_out}, 32'd0);
    check("resume_addr", Imem_addr_out, 32'h4);

    // Misaligned jump target faults; stray ack is ignored.
    do_instr(32'h4, 0, 0, 1'b0, 1'b1, 16'h0, 32'h102, 1'b0, 1'b0, c0);
    Imem_ack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("fault", {31'd0, Fault_out}, 32'd1);
      check("fault_noreq", {31'd0, Imem_req_out}, 32'd0);
      check("fault_novalid", {31'd0, Instr_valid_out}, 32'd0);
      check("fault_pc", Pc_out, 32'h4);
      tick();
      Imem_ack_in = 1'b0;
    end

    Rst_n_in = 1'b0;
    exp_retire = 32'd0;
    #1;
    check_reset_outputs();
    tick();
    Rst_n_in = 1'b1;
    tick();
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c0);
    check("midfetch_req", {31'd0, Imem_req_out}, 32'd1);
    #2;
    Rst_n_in = 1'b0;
    exp_retire = 32'd0;
    #1;
    check_reset_outputs();
    tick();
    Rst_n_in = 1'b1;
    tick();
    do_instr(32'h0, 1, 1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, c0);

    tick();
    check("sb_drained", exp_pc_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

`default_nettype wire
